rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the single write port of the 32x32 register file. It accepts write requests from up to NREQ execution sources (default ALU, load/store unit, multiply/divide unit) over valid/ready handshakes and grants one per cycle in round-robin order. The granted write is registered into a one-entry write stage that drives the register file's RegWr/rd/wdata. It also provides same-cycle forwarding of the in-flight write to the two register-file read ports, and counts contention cycles.

## Interface
- NREQ, 3, number of requesters; source 0 = ALU, 1 = LSU, 2 = MDU
- CNTW, 16, width of the contention counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-source write request
- req_rd  in  5*NREQ  destination register; source i at bits [5i+4:5i]
- req_data  in  32*NREQ  write data; source i at bits [32i+31:32i]
- req_ready  out  NREQ  grant/accept, one-hot or zero
- RegWr  out  1  register-file write enable
- rd  out  5  register-file write address
- wdata  out  32  register-file write data
- rs1, rs2  in  5 each  current read addresses of the register file
- fwd1_hit, fwd2_hit  out  1 each  in-flight write matches rs1 / rs2
- fwd_data  out  32  data to substitute on a hit; equals wdata
- conflict_cnt  out  CNTW  saturating count of contended cycles

## Operation
- Handshake: a transfer occurs on source i in a cycle where req_valid[i] && req_ready[i]. Once a requester asserts valid, it holds valid, rd and data stable until ready. The arbiter never withdraws a grant once it has been given.
- req_ready is combinational from req_valid and the priority pointer.
  - At most one bit of req_ready is set.
  - req_ready[i] is never set when req_valid[i] is 0.
  - The arbiter has no backpressure: if any valid is set, exactly one ready is set.
- Round robin:
  - ptr holds the highest-priority index. The search order is ptr, ptr+1, ..., wrapping modulo NREQ.
  - After a grant to i, ptr becomes (i+1) mod NREQ. ptr is unchanged in cycles with no grant.
- Write stage, updated every cycle:
  - On a transfer, it loads rd and data from the granted source. RegWr is set to 1 unless the source's rd == 0.
  - A write to r0 is accepted (ready=1) but produces RegWr=0 and is never forwarded.
  - With no transfer, RegWr = 0. rd and wdata hold their previous values (don't-care).
- Forwarding:
  - fwd1_hit = RegWr && rd != 0 && rd == rs1. fwd2_hit is the same with rs2.
  - fwd_data = wdata. This is purely combinational from the write stage and the rs inputs.
- Contention counter:
  - Increments in any cycle where two or more req_valid bits are set.
  - Saturates at all-ones and never wraps.
- Reset behaviour:
  - Reset sets ptr=0, RegWr=0, rd=0, wdata=0, conflict_cnt=0.
  - While rst=1, req_ready = 0 and no transfer occurs.
  - Reset asserted mid-operation drops the in-flight write: RegWr is 0 in the cycle after the reset edge. Requesters must re-present their requests.

## Timing
- Cycle N: transfer on source i (req_ready[i]=1).
- Cycle N+1: RegWr/rd/wdata carry that write, and forwarding is active. The register file commits it on the rising edge ending N+1.
- Latency from request to register-file commit is 1 cycle when uncontended. The worst case is NREQ cycles with all sources continuously valid.
- Throughput is one write per cycle. Back-to-back grants from the same source are allowed if it is the only valid source.
- Two sources targeting the same rd in consecutive cycles commit in grant order. The later grant wins in the register file.
- conflict_cnt reflects cycle N contention from cycle N+1 onward.

## Test plan
- Reset: hold rst 2 cycles with all valids set -> req_ready=000, RegWr=0, conflict_cnt=0, ptr=0. Then ALU writes r5=0x12345678 -> ready[0] in cycle 0; in cycle 1 RegWr=1, rd=5, wdata=0x12345678.
- Round robin: all three sources valid continuously (rd 1/2/3) -> grants in order 0,1,2,0,1,2. conflict_cnt increments every cycle. Each source waits at most 2 cycles.
- r0 write: LSU writes rd=0, data=0xDEADBEEF -> ready[1]=1 and the next cycle has RegWr=0. With rs1=0, fwd1_hit=0.
- Forwarding: MDU writes r7=0xA5A5A5A5 with rs1=7, rs2=8 in the following cycle -> fwd1_hit=1, fwd2_hit=0, fwd_data=0xA5A5A5A5. Two cycles later, a register-file read of r7 returns 0xA5A5A5A5.
- Saturation and reset mid-operation:
  - Preload via sustained contention with CNTW=4 -> count stops at 0xF.
  - Assert rst in the cycle after a grant -> RegWr=0 in the next cycle, counter=0, ptr=0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Write-back arbiter bus: requester handshakes, register-file write port,
// read-port forwarding and the contention counter output.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int CNTW = 16
);
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_rd;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               RegWr;
  logic [4:0]         rd;
  logic [31:0]        wdata;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic               fwd1_hit;
  logic               fwd2_hit;
  logic [31:0]        fwd_data;
  logic [CNTW-1:0]    conflict_cnt;

  // Arbiter side of the bus
  modport slave (
    input  req_valid, req_rd, req_data, rs1, rs2,
    output req_ready, RegWr, rd, wdata, fwd1_hit, fwd2_hit, fwd_data,
           conflict_cnt
  );

  // Requester / register-file side of the bus
  modport master (
    output req_valid, req_rd, req_data, rs1, rs2,
    input  req_ready, RegWr, rd, wdata, fwd1_hit, fwd2_hit, fwd_data,
           conflict_cnt
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port.
// One request is granted per cycle, registered into a one-entry write stage,
// and the in-flight write is forwarded to the two read ports.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  rf_wb_arbiter_if.slave  bus
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0] ptr_q;
  logic [PTRW-1:0] ptr_d;

  logic            grantFound;
  logic [PTRW-1:0] grantNext;
  logic [NREQ-1:0] grantOneHot;
  logic [4:0]      grantRd;
  logic [31:0]     grantData;
  logic            transfer;

  logic            regWr_q;
  logic            regWr_d;
  logic [4:0]      rd_q;
  logic [4:0]      rd_d;
  logic [31:0]     wdata_q;
  logic [31:0]     wdata_d;

  logic            contended;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  // Round-robin search: first the indices at or above the pointer, then the
  // ones below it, so the search order is ptr, ptr+1, ... wrapping around.
  always_comb begin
    grantFound  = 1'b0;
    grantNext   = '0;
    grantOneHot = '0;
    grantRd     = '0;
    grantData   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grantFound && bus.req_valid[i] && (i >= int'(ptr_q))) begin
        grantFound     = 1'b1;
        grantOneHot[i] = 1'b1;
        grantRd        = bus.req_rd[i*5 +: 5];
        grantData      = bus.req_data[i*32 +: 32];
        grantNext      = (i == NREQ - 1) ? '0 : PTRW'(i + 1);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grantFound && bus.req_valid[i] && (i < int'(ptr_q))) begin
        grantFound     = 1'b1;
        grantOneHot[i] = 1'b1;
        grantRd        = bus.req_rd[i*5 +: 5];
        grantData      = bus.req_data[i*32 +: 32];
        grantNext      = (i == NREQ - 1) ? '0 : PTRW'(i + 1);
      end
    end
  end

  // Grants are suppressed during reset so nothing is accepted that would be
  // dropped by the write stage being cleared.
  assign transfer      = grantFound && !rst;
  assign bus.req_ready = rst ? '0 : grantOneHot;

  // Next-state for pointer, write stage and saturating contention counter.
  always_comb begin
    ptr_d     = ptr_q;
    regWr_d   = 1'b0;
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    contended = ($countones(bus.req_valid) > 1);
    if (transfer) begin
      ptr_d   = grantNext;
      regWr_d = (grantRd != 5'd0);
      rd_d    = grantRd;
      wdata_d = grantData;
    end
    if (contended && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // State registers with synchronous reset; reset also drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      regWr_q <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      regWr_q <= regWr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.RegWr        = regWr_q;
  assign bus.rd           = rd_q;
  assign bus.wdata        = wdata_q;
  assign bus.conflict_cnt = cnt_q;

  // Forwarding never hits on r0, and only while a real write is in flight.
  assign bus.fwd1_hit = regWr_q && (rd_q != 5'd0) && (rd_q == bus.rs1);
  assign bus.fwd2_hit = regWr_q && (rd_q != 5'd0) && (rd_q == bus.rs2);
  assign bus.fwd_data = wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter (3 requesters, 4-bit counter so
// saturation is reachable quickly).
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int CNTW = 4;

  localparam logic [31:0] DA = 32'h000000A0;
  localparam logic [31:0] DB = 32'h000000B1;
  localparam logic [31:0] DC = 32'h000000C2;

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic [4:0]  rs1, rs2;
    logic [2:0]  expReady;
    logic        chkRegs;
    logic        expRegWr;
    logic        chkData;
    logic [4:0]  expRd;
    logic [31:0] expWdata;
    logic        expFwd1, expFwd2;
    logic [3:0]  expCnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];
  logic [31:0] rfModel [32];

  rf_wb_arbiter_if #(.NREQ(NREQ), .CNTW(CNTW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file stand-in that commits whatever the write port presents
  always @(posedge clk) begin
    if (bus.RegWr && (bus.rd != 5'd0)) rfModel[bus.rd] <= bus.wdata;
  end

  function automatic vec_t mkVec(
    input logic r, input logic [2:0] v,
    input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
    input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
    input logic [4:0] s1, input logic [4:0] s2,
    input logic [2:0] er, input logic cr, input logic ew, input logic cd,
    input logic [4:0] erd, input logic [31:0] ewd,
    input logic ef1, input logic ef2, input logic [3:0] ec);
    vec_t t;
    t.rst = r;  t.valid = v;
    t.rd0 = a0; t.rd1 = a1; t.rd2 = a2;
    t.d0 = x0;  t.d1 = x1;  t.d2 = x2;
    t.rs1 = s1; t.rs2 = s2;
    t.expReady = er; t.chkRegs = cr; t.expRegWr = ew; t.chkData = cd;
    t.expRd = erd; t.expWdata = ewd;
    t.expFwd1 = ef1; t.expFwd2 = ef2; t.expCnt = ec;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst           = t.rst;
    bus.req_valid = t.valid;
    bus.req_rd    = {t.rd2, t.rd1, t.rd0};
    bus.req_data  = {t.d2, t.d1, t.d0};
    bus.rs1       = t.rs1;
    bus.rs2       = t.rs2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Table of per-cycle vectors followed by the multi-cycle corner sequences
  initial begin
    vec_t t;
    checks = 0;
    errors = 0;
    for (int r = 0; r < 32; r++) rfModel[r] = '0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;

    //                 rst valid  rd0 rd1 rd2 d0            d1            d2            rs1 rs2  rdy  cR ew cD erd ewd           f1 f2 cnt
    vecs.push_back(mkVec(1, 3'b111, 1, 2, 3, DA,           DB,           DC,           0, 0, 3'b000, 0, 0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mkVec(1, 3'b111, 1, 2, 3, DA,           DB,           DC,           0, 0, 3'b000, 1, 0, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mkVec(0, 3'b001, 5, 0, 0, 32'h12345678, 0,            0,            0, 0, 3'b001, 1, 0, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mkVec(0, 3'b000, 5, 0, 0, 32'h12345678, 0,            0,            5, 0, 3'b000, 1, 1, 1, 5, 32'h12345678, 1, 0, 0));
    vecs.push_back(mkVec(0, 3'b111, 1, 2, 3, DA,           DB,           DC,           0, 0, 3'b010, 1, 0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mkVec(0, 3'b111, 1, 2, 3, DA,           DB,           DC,           2, 2, 3'b100, 1, 1, 1, 2, DB,           1, 1, 1));
    vecs.push_back(mkVec(0, 3'b111, 1, 2, 3, DA,           DB,           DC,           3, 1, 3'b001, 1, 1, 1, 3, DC,           1, 0, 2));
    vecs.push_back(mkVec(0, 3'b111, 1, 2, 3, DA,           DB,           DC,           0, 0, 3'b010, 1, 1, 1, 1, DA,           0, 0, 3));
    vecs.push_back(mkVec(0, 3'b111, 1, 2, 3, DA,           DB,           DC,           0, 0, 3'b100, 1, 1, 1, 2, DB,           0, 0, 4));
    vecs.push_back(mkVec(0, 3'b111, 1, 2, 3, DA,           DB,           DC,           0, 0, 3'b001, 1, 1, 1, 3, DC,           0, 0, 5));
    vecs.push_back(mkVec(0, 3'b000, 1, 2, 3, DA,           DB,           DC,           0, 0, 3'b000, 1, 1, 1, 1, DA,           0, 0, 6));
    vecs.push_back(mkVec(0, 3'b010, 0, 0, 0, 0,            32'hDEADBEEF, 0,            0, 0, 3'b010, 1, 0, 0, 0, 32'h0,        0, 0, 6));
    vecs.push_back(mkVec(0, 3'b000, 0, 0, 0, 0,            32'hDEADBEEF, 0,            0, 0, 3'b000, 1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 6));
    vecs.push_back(mkVec(0, 3'b100, 0, 0, 7, 0,            0,            32'hA5A5A5A5, 0, 0, 3'b100, 1, 0, 0, 0, 32'h0,        0, 0, 6));
    vecs.push_back(mkVec(0, 3'b000, 0, 0, 7, 0,            0,            32'hA5A5A5A5, 7, 8, 3'b000, 1, 1, 1, 7, 32'hA5A5A5A5, 1, 0, 6));
    vecs.push_back(mkVec(0, 3'b000, 0, 0, 7, 0,            0,            32'hA5A5A5A5, 7, 0, 3'b000, 1, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 6));
    vecs.push_back(mkVec(0, 3'b001, 9, 0, 0, 32'h11111111, 0,            0,            0, 0, 3'b001, 1, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 6));
    vecs.push_back(mkVec(0, 3'b001, 9, 0, 0, 32'h22222222, 0,            0,            9, 9, 3'b001, 1, 1, 1, 9, 32'h11111111, 1, 1, 6));
    vecs.push_back(mkVec(0, 3'b000, 9, 0, 0, 32'h22222222, 0,            0,            9, 0, 3'b000, 1, 1, 1, 9, 32'h22222222, 1, 0, 6));
    vecs.push_back(mkVec(0, 3'b101, 4, 0, 6, 32'h00000044, 0,            32'h00000066, 0, 0, 3'b100, 1, 0, 1, 9, 32'h22222222, 0, 0, 6));
    vecs.push_back(mkVec(0, 3'b001, 4, 0, 6, 32'h00000044, 0,            32'h00000066, 0, 0, 3'b001, 1, 1, 1, 6, 32'h00000066, 0, 0, 7));
    vecs.push_back(mkVec(0, 3'b000, 4, 0, 6, 32'h00000044, 0,            32'h00000066, 0, 0, 3'b000, 1, 1, 1, 4, 32'h00000044, 0, 0, 7));

    foreach (vecs[i]) begin
      t = vecs[i];
      nextCycle();
      applyStimulus(t);
      @(negedge clk);
      checkOutput($sformatf("v%0d.req_ready", i), 32'(bus.req_ready), 32'(t.expReady));
      if (t.chkRegs) begin
        checkOutput($sformatf("v%0d.RegWr", i), 32'(bus.RegWr), 32'(t.expRegWr));
        checkOutput($sformatf("v%0d.fwd1_hit", i), 32'(bus.fwd1_hit), 32'(t.expFwd1));
        checkOutput($sformatf("v%0d.fwd2_hit", i), 32'(bus.fwd2_hit), 32'(t.expFwd2));
        checkOutput($sformatf("v%0d.conflict_cnt", i), 32'(bus.conflict_cnt), 32'(t.expCnt));
      end
      if (t.chkData) begin
        checkOutput($sformatf("v%0d.rd", i), 32'(bus.rd), 32'(t.expRd));
        checkOutput($sformatf("v%0d.wdata", i), bus.wdata, t.expWdata);
        checkOutput($sformatf("v%0d.fwd_data", i), bus.fwd_data, t.expWdata);
      end
    end

    // Committed register contents: forwarded r7 value, and r9 holding the later write
    checkOutput("rf.r7", rfModel[7], 32'hA5A5A5A5);
    checkOutput("rf.r9", rfModel[9], 32'h22222222);

    // Sustained contention from ptr=1, count=7: rotation continues and count sticks at 0xF
    for (int k = 0; k < 12; k++) begin
      int expCnt;
      logic [2:0] expReady;
      nextCycle();
      bus.req_valid = 3'b111;
      bus.req_rd    = {5'd3, 5'd2, 5'd1};
      bus.req_data  = {DC, DB, DA};
      @(negedge clk);
      expReady = 3'b001 << ((1 + k) % 3);
      expCnt   = (7 + k > 15) ? 15 : 7 + k;
      checkOutput($sformatf("sat%0d.req_ready", k), 32'(bus.req_ready), 32'(expReady));
      checkOutput($sformatf("sat%0d.conflict_cnt", k), 32'(bus.conflict_cnt), 32'(expCnt));
    end

    // Grant to ALU moves ptr to 1; reset in the following cycle must drop it
    nextCycle();
    bus.req_valid = 3'b001;
    bus.req_rd    = {5'd3, 5'd2, 5'd12};
    bus.req_data  = {DC, DB, 32'hCAFE0001};
    @(negedge clk);
    checkOutput("rstA.req_ready", 32'(bus.req_ready), 32'(3'b001));

    nextCycle();
    rst = 1'b1;
    bus.req_valid = 3'b111;
    @(negedge clk);
    checkOutput("rstB.req_ready", 32'(bus.req_ready), 32'(3'b000));
    checkOutput("rstB.RegWr", 32'(bus.RegWr), 32'(1'b1));
    checkOutput("rstB.rd", 32'(bus.rd), 32'(5'd12));

    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstC.RegWr", 32'(bus.RegWr), 32'(1'b0));
    checkOutput("rstC.conflict_cnt", 32'(bus.conflict_cnt), 32'(0));
    checkOutput("rstC.req_ready", 32'(bus.req_ready), 32'(3'b001));

    nextCycle();
    bus.req_valid = 3'b000;
    @(negedge clk);
    checkOutput("rstD.RegWr", 32'(bus.RegWr), 32'(1'b1));
    checkOutput("rstD.rd", 32'(bus.rd), 32'(5'd12));
    checkOutput("rstD.conflict_cnt", 32'(bus.conflict_cnt), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
